// File: rtl/clkdiv_ctrl_pkg.sv
// Shared definitions for the divided-clock controller.
// Holds the FSM state encoding and the parameter defaults.
package clkdiv_ctrl_pkg;

    localparam int CNT_W_DEF       = 8;
    localparam int DEFAULT_DIV_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

endpackage

// File: rtl/clkdiv_phase_cnt.sv
// Loadable 0..N-1 phase counter for the divided-clock controller.
// Flags the last phase of a period and the high half of the next phase.
module clkdiv_phase_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_adv,
    input  logic [CNT_W-1:0] i_div,
    input  logic [CNT_W-1:0] i_div_nxt,
    output logic             o_wrap,
    output logic [CNT_W-1:0] o_phase_nxt,
    output logic             o_high_nxt
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_phase;
    logic             w_wrap;
    logic [CNT_W-1:0] w_phase_nxt;
    logic [CNT_W-1:0] w_hi_len;

    assign w_wrap      = (r_phase == i_div - ONE);
    // Clearing when not advancing holds phase 0 in IDLE and restarts it on entry to RUN.
    assign w_phase_nxt = (!i_adv || w_wrap) ? '0 : r_phase + ONE;
    // ceil(N/2) without a CNT_W+1 bit intermediate, so N = 2**CNT_W-1 cannot overflow.
    assign w_hi_len    = (i_div_nxt >> 1) + {{(CNT_W-1){1'b0}}, i_div_nxt[0]};

    assign o_wrap      = w_wrap;
    assign o_phase_nxt = w_phase_nxt;
    assign o_high_nxt  = (w_phase_nxt < w_hi_len);

    always_ff @(posedge clk) begin
        if (rst) r_phase <= '0;
        else     r_phase <= w_phase_nxt;
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Run-time divide-ratio controller: FSM, one-entry pending ratio and config handshake.
// Produces a registered per-period enable pulse and a near-50% duty level on clk.
module clkdiv_ctrl
    import clkdiv_ctrl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_en,
    output logic             div_out,
    output logic             busy
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_div, w_div_nxt;
    logic [CNT_W-1:0] r_pend, w_pend_nxt;
    logic             r_pend_vld, w_pend_vld_nxt;
    logic             w_accept, w_legal, w_wrap, w_adv, w_run_nxt, w_high_nxt;
    logic [CNT_W-1:0] w_phase_nxt;

    assign w_accept  = cfg_valid && cfg_ready;
    assign w_legal   = w_accept && (cfg_div != '0);
    assign w_run_nxt = (w_state_nxt != ST_IDLE);
    assign w_adv     = (r_state != ST_IDLE) && w_run_nxt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        case (r_state)
            ST_IDLE: begin
                if (en_i)    w_state_nxt = ST_RUN;
                if (w_legal) w_div_nxt   = cfg_div;
            end
            default: begin
                // Leaving only on the last phase keeps the final period full length.
                if (!en_i && w_wrap) w_state_nxt = ST_IDLE;
                else if (!en_i)      w_state_nxt = ST_STOP;
                else                 w_state_nxt = ST_RUN;
                if (w_wrap && r_pend_vld) begin
                    w_div_nxt      = r_pend;
                    w_pend_vld_nxt = 1'b0;
                end
                if (w_legal) begin
                    if (w_state_nxt == ST_IDLE) begin
                        w_div_nxt = cfg_div;
                    end else begin
                        w_pend_nxt     = cfg_div;
                        w_pend_vld_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    clkdiv_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_adv       (w_adv),
        .i_div       (r_div),
        .i_div_nxt   (w_div_nxt),
        .o_wrap      (w_wrap),
        .o_phase_nxt (w_phase_nxt),
        .o_high_nxt  (w_high_nxt)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div      <= DEF_DIV;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            cfg_ready  <= 1'b1;
            cfg_err    <= 1'b0;
            div_en     <= 1'b0;
            div_out    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_div      <= w_div_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            cfg_ready  <= !w_pend_vld_nxt;
            cfg_err    <= w_accept && (cfg_div == '0);
            div_en     <= w_run_nxt && (w_phase_nxt == '0);
            div_out    <= w_run_nxt && w_high_nxt;
            busy       <= w_run_nxt;
        end
    end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Scoreboard bench for clkdiv_ctrl: directed scenarios then random traffic,
// each cycle's expected outputs come from a period-level reference model.
module tb_clkdiv_ctrl;

    localparam int CNT_W = 8;
    localparam int DEF_N = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             en_i;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready, cfg_err, div_en, div_out, busy;

    typedef struct packed {
        logic ready;
        logic err;
        logic en;
        logic out;
        logic busy;
    } obs_t;

    obs_t  exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    string scen     = "reset";

    // Reference model: a run flag, phase within period, active ratio, pending queue.
    bit m_active;
    int m_phase;
    int m_n;
    int m_pend[$];

    clkdiv_ctrl #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en_i),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_en    (div_en),
        .div_out   (div_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: ready/err/en/out/busy got %b required %b",
                     name, cyc, act, exp);
        end
    endtask

    // Advance the model across one clock edge with the given inputs.
    task automatic model_step(input bit r, input bit e, input bit v, input int d,
                              output obs_t o);
        bit accept, legal, last;
        if (r) begin
            m_active = 1'b0;
            m_phase  = 0;
            m_n      = DEF_N;
            m_pend.delete();
            o = '{ready: 1'b1, err: 1'b0, en: 1'b0, out: 1'b0, busy: 1'b0};
            return;
        end
        accept = v && (m_pend.size() == 0);
        legal  = accept && (d != 0);
        if (!m_active) begin
            if (legal) m_n = d;
            if (e) begin
                m_active = 1'b1;
                m_phase  = 0;
            end
        end else begin
            last = (m_phase == m_n - 1);
            if (last && m_pend.size() != 0) m_n = m_pend.pop_front();
            if (last && !e) begin
                m_active = 1'b0;
                m_phase  = 0;
                if (legal) m_n = d;
            end else begin
                m_phase = last ? 0 : m_phase + 1;
                if (legal) m_pend.push_back(d);
            end
        end
        o.ready = (m_pend.size() == 0);
        o.err   = accept && (d == 0);
        o.busy  = m_active;
        o.en    = m_active && (m_phase == 0);
        o.out   = m_active && (m_phase < (m_n + 1) / 2);
    endtask

    task automatic drive(input bit r, input bit e, input bit v, input int d);
        obs_t o;
        rst       = r;
        en_i      = e;
        cfg_valid = v;
        cfg_div   = CNT_W'(d);
        model_step(r, e, v, d, o);
        exp_q.push_back(o);
        @(posedge clk);
        #2;
    endtask

    task automatic idle_cycles(input bit e, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, e, 1'b0, 0);
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 300 && !(m_active && m_phase == p); i++)
            drive(1'b0, 1'b1, 1'b0, 0);
    endtask

    // Monitor: pops one expectation per edge and compares it with the DUT.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard cycle %0d: got no expectation required one", cyc);
            end else begin
                e = exp_q.pop_front();
                a = '{ready: cfg_ready, err: cfg_err, en: div_en, out: div_out, busy: busy};
                check(scen, a, e);
            end
        end
    end

    initial begin
        bit en_r;
        int d;
        scen = "reset";
        drive(1'b1, 1'b0, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b0, 0);

        scen = "run_n5";
        idle_cycles(1'b1, 16);

        scen = "pend_n4";
        wait_phase(2);
        drive(1'b0, 1'b1, 1'b1, 4);
        idle_cycles(1'b1, 14);

        scen = "stop_at_p1";
        drive(1'b1, 1'b0, 1'b0, 0);
        idle_cycles(1'b1, 6);
        wait_phase(1);
        idle_cycles(1'b0, 10);

        scen = "err_idle";
        drive(1'b0, 1'b0, 1'b1, 0);
        idle_cycles(1'b0, 2);
        idle_cycles(1'b1, 12);
        idle_cycles(1'b0, 8);

        scen = "n1_to_n255";
        drive(1'b0, 1'b0, 1'b1, 1);
        idle_cycles(1'b1, 8);
        drive(1'b0, 1'b1, 1'b1, 255);
        idle_cycles(1'b1, 600);
        idle_cycles(1'b0, 300);

        scen = "rst_mid";
        idle_cycles(1'b1, 4);
        drive(1'b0, 1'b1, 1'b1, 7);
        wait_phase(3);
        drive(1'b1, 1'b1, 1'b0, 0);
        idle_cycles(1'b0, 2);
        idle_cycles(1'b1, 12);

        scen = "random";
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) en_r = !en_r;
            case ($urandom_range(0, 9))
                0:       d = 0;
                1:       d = $urandom_range(0, 255);
                default: d = $urandom_range(1, 9);
            endcase
            drive($urandom_range(0, 299) == 0, en_r, $urandom_range(0, 5) == 0, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
